// File: rtl/pq_candidate_arbiter.sv
// Round-robin arbiter sharing the pq candidate FIFO between the P and Q searches.
// Rejects even candidates, and Q candidates that repeat the last value given to P.
module pq_candidate_arbiter #(
  parameter int DATA_W    = 128,
  parameter int CNT_W     = 16,
  parameter int REJ_LIMIT = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] pq_fifo_dout,
  input  logic              pq_fifo_empty,
  output logic              pq_fifo_rd_en,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic [1:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              rej_err
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CHK, S_DLV} state_t;

  localparam logic [CNT_W-1:0] REJ_LIM = CNT_W'(REJ_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                rr_q, rr_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   last_p_q, last_p_d;
  logic                last_p_vld_q, last_p_vld_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic                rej_err_q, rej_err_d;

  logic                owner;
  logic                grant_held;
  logic                pick_idx;
  logic                reject;
  logic [CNT_W-1:0]    drop_inc;
  logic [CNT_W-1:0]    run_inc;

  // Owner index is the high bit of the one-hot grant: 0 = P, 1 = Q.
  assign owner      = gnt_q[1];
  assign grant_held = |gnt_q;
  assign pick_idx   = req[rr_q] ? rr_q : ~rr_q;
  assign reject     = ~cand_q[0] | (owner & last_p_vld_q & (cand_q == last_p_q));
  assign drop_inc   = (drop_cnt_q == CNT_MAX) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
  assign run_inc    = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_d          = rr_q;
    cand_d        = cand_q;
    out_data_d    = out_data_q;
    last_p_d      = last_p_q;
    last_p_vld_d  = last_p_vld_q;
    drop_cnt_d    = drop_cnt_q;
    run_d         = run_q;
    rej_err_d     = rej_err_q;
    pq_fifo_rd_en = 1'b0;
    out_valid     = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (!grant_held) begin
          if (|req) begin
            gnt_d = pick_idx ? 2'b10 : 2'b01;
            if (!pq_fifo_empty) state_d = S_RD;
          end
        end else if (!req[owner]) begin
          gnt_d = 2'b00;
        end else if (!pq_fifo_empty) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        // Guarding on empty here keeps the strobe legal even if the flag moves under us.
        if (!pq_fifo_empty) begin
          pq_fifo_rd_en = 1'b1;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        cand_d  = pq_fifo_dout;
        state_d = S_CHK;
      end
      S_CHK: begin
        if (!req[owner]) begin
          drop_cnt_d = drop_inc;
          gnt_d      = 2'b00;
          state_d    = S_IDLE;
        end else if (reject) begin
          drop_cnt_d = drop_inc;
          run_d      = run_inc;
          if (run_inc >= REJ_LIM) rej_err_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          run_d      = '0;
          out_data_d = cand_q;
          state_d    = S_DLV;
        end
      end
      S_DLV: begin
        out_valid = owner ? 2'b10 : 2'b01;
        if (!owner) begin
          last_p_d     = cand_q;
          last_p_vld_d = 1'b1;
        end
        rr_d    = ~owner;
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      gnt_q        <= 2'b00;
      rr_q         <= 1'b0;
      cand_q       <= '0;
      out_data_q   <= '0;
      last_p_q     <= '0;
      last_p_vld_q <= 1'b0;
      drop_cnt_q   <= '0;
      run_q        <= '0;
      rej_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      cand_q       <= cand_d;
      out_data_q   <= out_data_d;
      last_p_q     <= last_p_d;
      last_p_vld_q <= last_p_vld_d;
      drop_cnt_q   <= drop_cnt_d;
      run_q        <= run_d;
      rej_err_q    <= rej_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign out_data = out_data_q;
  assign busy     = (state_q != S_IDLE) | grant_held;
  assign drop_cnt = drop_cnt_q;
  assign rej_err  = rej_err_q;

endmodule
